// File: rtl/dpram_pkg.sv
// Shared constants for the single-clock simple dual-port RAM.
// Read-during-write policy codes and the clear-sweep state encoding.
package dpram_pkg;

  localparam logic RDW_WRITE_FIRST = 1'b1;
  localparam logic RDW_READ_FIRST  = 1'b0;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/dpram_init_ctrl.sv
// Post-reset clear sweep: walks every address once, writing zero, then hands over to RUN.
// Latency: exactly 2**ADDR_W cycles after reset release; no backpressure, cannot be stalled.
// Backpressure: none; the user ports are simply locked out while init_busy is high.
module dpram_init_ctrl
  import dpram_pkg::*;
#(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  output logic              init_busy,
  output logic [ADDR_W-1:0] sweep_addr,
  output logic              sweep_we
);

  state_t            state;
  logic [ADDR_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else if (state == ST_INIT) begin
      cnt <= cnt + 1'b1;
      // last address written on this edge, so RUN starts on the next cycle
      if (&cnt) state <= ST_RUN;
    end
  end

  assign init_busy  = (state == ST_INIT);
  assign sweep_addr = cnt;
  assign sweep_we   = (state == ST_INIT) && !reset;

endmodule

// File: rtl/dpram_sclk_param.sv
// Single-clock simple dual-port RAM with clear sweep, read-valid, RDW policy and collision flag.
// Latency: read data 1 cycle after re (2 with DPRAM_OUT_REG_EN defined).
// Backpressure: none; each result is presented for exactly one cycle.
module dpram_sclk_param
  import dpram_pkg::*;
#(
  parameter int   DATA_W   = 10,
  parameter int   ADDR_W   = 3,
  parameter logic RDW_MODE = RDW_WRITE_FIRST
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              coll,
  output logic              init_busy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] sweep_addr;
  logic              sweep_we;
  logic              hit;
  logic [DATA_W-1:0] rd_q;
  logic              rv_q;
  logic              coll_q;

  dpram_init_ctrl #(.ADDR_W(ADDR_W)) u_init (
    .clk        (clk),
    .reset      (reset),
    .init_busy  (init_busy),
    .sweep_addr (sweep_addr),
    .sweep_we   (sweep_we)
  );

  assign hit = we && re && (waddr == raddr);

  // Sweep owns the write port until RUN; user writes are dropped, not deferred.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[sweep_addr] <= '0;
    end else if (we && !init_busy && !reset) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || init_busy) begin
      rd_q   <= '0;
      rv_q   <= 1'b0;
      coll_q <= 1'b0;
    end else begin
      rv_q   <= re;
      coll_q <= hit;
      if (!re) begin
        rd_q <= '0;
      end else if (hit && (RDW_MODE == RDW_WRITE_FIRST)) begin
        rd_q <= wdata;
      end else begin
        rd_q <= mem[raddr];
      end
    end
  end

`ifdef DPRAM_OUT_REG_EN
  logic [DATA_W-1:0] rd_p;
  logic              rv_p;
  logic              coll_p;

  always_ff @(posedge clk) begin
    if (reset || init_busy) begin
      rd_p   <= '0;
      rv_p   <= 1'b0;
      coll_p <= 1'b0;
    end else begin
      rd_p   <= rd_q;
      rv_p   <= rv_q;
      coll_p <= coll_q;
    end
  end

  assign rdata  = rd_p;
  assign rvalid = rv_p;
  assign coll   = coll_p;
`else
  assign rdata  = rd_q;
  assign rvalid = rv_q;
  assign coll   = coll_q;
`endif

endmodule
